eco_sweep_ctrl: RTL and testbench
=================================

Name: eco_sweep_ctrl

Overview:
Exhaustive equivalence-sweep controller for small ECO-patched combinational netlists (4-bit a/b in, 4-bit y out).
- Drives every a/b input combination into a patched netlist and a golden netlist, both instantiated outside this block.
- Waits a programmable settle time, then compares the two outputs.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits in the ECO regression harness, one instance per patched netlist.

Parameters:
- DW, 4, width of each netlist input (a, b) and of the output y; sweep space is 2^(2*DW) vectors.
- SETTLE, 1, idle cycles after driving a vector before sampling outputs; SETTLE=0 means sample on the next cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only when idle.
- a_out  output  DW  a stimulus to both netlists; equals vec[DW-1:0].
- b_out  output  DW  b stimulus to both netlists; equals vec[2*DW-1:DW].
- y_impl  input  DW  output of the patched netlist.
- y_gold  input  DW  output of the golden netlist.
- busy  output  1  high from start accept until DONE is left.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 when the last sweep had zero mismatches; held until the next start.
- mismatch_cnt  output  2*DW+1  number of mismatching vectors in the last sweep (max 2^(2*DW), no saturation needed).
- first_fail_vec  output  2*DW  {b,a} of the first mismatch; 0 if none.
- first_fail_xor  output  DW  y_impl^y_gold at the first mismatch; 0 if none.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; vec, a_out, b_out, mismatch_cnt, first_fail_vec, first_fail_xor = 0.
  - busy, done, pass = 0.
  - Reset mid-sweep aborts immediately; no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1: vec<=0, mismatch_cnt<=0, first_fail_* <=0, pass<=0, settle counter<=SETTLE.
  - Next state is SETTLE if SETTLE>0, else SAMPLE.
  - This clock edge is the accept edge E0.
- SETTLE: counter decrements each cycle; on the cycle it reaches 1, next state is SAMPLE.
- SAMPLE, comparing y_impl vs y_gold (all DW bits):
  - On mismatch: mismatch_cnt+1.
  - If this is the first mismatch of the sweep: first_fail_vec<=vec, first_fail_xor<=y_impl^y_gold.
  - If vec is all ones: next state DONE.
  - Otherwise: vec+1, counter reloaded, next state SETTLE (or SAMPLE if SETTLE=0).
- DONE: done=1 for exactly one cycle, pass<=(mismatch_cnt==0), then IDLE.
- Timing:
  - Vector k is sampled at edge (k+1)*(SETTLE+1) after E0.
  - DONE is entered at edge 2^(2*DW)*(SETTLE+1); done is visible for the following cycle only.
  - a_out/b_out are registered and change only on the edge that advances vec.
- busy=1 in SETTLE, SAMPLE and DONE; 0 in IDLE.
- Start handling:
  - start while busy is ignored; no restart, no effect on counters.
  - start coincident with done (DONE state) is ignored.
- After DONE, a_out/b_out hold the last vector (all ones) until the next start.

Optional Feature:
Macro ECO_SWEEP_STOP_ON_FAIL_EN.
- Defined: on the first mismatch, SAMPLE goes directly to DONE without incrementing vec. mismatch_cnt ends at 1, pass=0, and a_out/b_out hold the failing vector.
- Undefined: the full space is always swept, as described above.

Test Plan:
- DW=4, SETTLE=1, y_impl tied to y_gold, start at E0 -> done pulse at edge 512, pass=1, mismatch_cnt=0, first_fail_vec=0x00, first_fail_xor=0x0.
- y_impl=y_gold^4'b0001 only when {b,a}=0x37 -> mismatch_cnt=1, pass=0, first_fail_vec=0x37, first_fail_xor=4'b0001.
- y_impl=~y_gold always -> mismatch_cnt=256, first_fail_vec=0x00, first_fail_xor=4'hF.
- start pulsed again at edge 100 of a running sweep -> ignored; done still at edge 512, counts unchanged.
- rst_n low when vec=0x80 -> all outputs 0 and IDLE asynchronously, no done; a new start gives a full clean sweep.
- With ECO_SWEEP_STOP_ON_FAIL_EN and the mismatch at 0x37 -> done at edge 112, mismatch_cnt=1, a_out=4'h7, b_out=4'h3.

Source files
------------

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive {b,a} sweep comparing a patched netlist against its golden twin.
// Optional ECO_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module eco_sweep_ctrl #(
    parameter int DW     = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    input  logic [DW-1:0]   y_impl,
    input  logic [DW-1:0]   y_gold,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [2*DW:0]   mismatch_cnt,
    output logic [2*DW-1:0] first_fail_vec,
    output logic [DW-1:0]   first_fail_xor
);

    localparam int VW = 2 * DW;
    localparam int MW = 2 * DW + 1;
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    // State entered after driving a new vector.
    localparam logic [1:0] S_RUN = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

    logic [1:0]    state_q, state_d;
    logic [VW-1:0] vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [VW-1:0] ffv_q, ffv_d;
    logic [DW-1:0] ffx_q, ffx_d;
    logic          pass_q, pass_d;

    logic mism;
    logic last;
    logic end_now;

    assign mism = (y_impl != y_gold);
    assign last = &vec_q;
`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
    assign end_now = last | mism;
`else
    assign end_now = last;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        ffv_d   = ffv_q;
        ffx_d   = ffx_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d   = '0;
                    mcnt_d  = '0;
                    ffv_d   = '0;
                    ffx_d   = '0;
                    pass_d  = 1'b0;
                    cnt_d   = CW'(SETTLE);
                    state_d = S_RUN;
                end
            end
            S_SETTLE: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (mism) begin
                    mcnt_d = mcnt_q + MW'(1);
                    if (mcnt_q == '0) begin
                        ffv_d = vec_q;
                        ffx_d = y_impl ^ y_gold;
                    end
                end
                if (end_now) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + VW'(1);
                    cnt_d   = CW'(SETTLE);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                pass_d  = (mcnt_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            ffv_q   <= '0;
            ffx_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            ffv_q   <= ffv_d;
            ffx_q   <= ffx_d;
            pass_q  <= pass_d;
        end
    end

    assign a_out          = vec_q[DW-1:0];
    assign b_out          = vec_q[VW-1:DW];
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign mismatch_cnt   = mcnt_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_xor = ffx_q;

endmodule

// File: tb/tb_eco_sweep_ctrl.sv
// Bench for eco_sweep_ctrl: timeline model of each sweep plus literal checks.
// Follows ECO_SWEEP_STOP_ON_FAIL_EN when the build defines it.
module tb_eco_sweep_ctrl;

    localparam int DW     = 4;
    localparam int SETTLE = 1;
    localparam int S1     = SETTLE + 1;
    localparam int NV     = 256;
`ifdef ECO_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_out, b_out, y_impl, y_gold;
    logic       busy, done, pass;
    logic [8:0] mismatch_cnt;
    logic [7:0] first_fail_vec;
    logic [3:0] first_fail_xor;

    int errors = 0;
    int checks = 0;
    int mode = 0;
    int m_mode = 0;
    int m_n = 0;
    bit m_started = 1'b0;
    int e;

    eco_sweep_ctrl #(.DW(DW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out),
        .y_impl(y_impl), .y_gold(y_gold),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt),
        .first_fail_vec(first_fail_vec),
        .first_fail_xor(first_fail_xor)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] fault(int md, int k);
        case (md)
            1: return (k == 8'h37) ? 4'h1 : 4'h0;
            2: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    assign y_gold = a_out + b_out;
    assign y_impl = y_gold ^ fault(mode, int'({b_out, a_out}));

    function automatic int first_k(int md);
        for (int k = 0; k < NV; k++)
            if (fault(md, k) != 4'h0) return k;
        return -1;
    endfunction

    function automatic int last_vec(int md);
        if (STOP && first_k(md) >= 0) return first_k(md);
        return NV - 1;
    endfunction

    function automatic int done_edge(int md);
        return (last_vec(md) + 1) * S1;
    endfunction

    // Edges counted from the accept edge (n=0 right after it).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_n       <= 0;
        end else if (start && (!m_started || m_n > done_edge(m_mode))) begin
            m_started <= 1'b1;
            m_n       <= 0;
            m_mode    <= mode;
        end else if (m_started && m_n < 100000) begin
            m_n <= m_n + 1;
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int d, lim, c, f, v;
        bit eb, ed, ep;
        if (rst_n) begin
            c = 0; f = 0; v = 0; eb = 0; ed = 0; ep = 0;
            if (m_started) begin
                d   = done_edge(m_mode);
                lim = (m_n < d) ? m_n : d;
                for (int k = 0; k < NV; k++) begin
                    if ((k + 1) * S1 <= lim && fault(m_mode, k) != 4'h0) begin
                        if (c == 0) f = k;
                        c++;
                    end
                end
                v  = m_n / S1;
                if (v > last_vec(m_mode)) v = last_vec(m_mode);
                eb = (m_n <= d);
                ed = (m_n == d);
                ep = (m_n > d) && (c == 0);
            end
            check("busy", int'(busy), int'(eb));
            check("done", int'(done), int'(ed));
            check("pass", int'(pass), int'(ep));
            check("mismatch_cnt", int'(mismatch_cnt), c);
            check("first_fail_vec", int'(first_fail_vec), f);
            check("first_fail_xor", int'(first_fail_vec == 8'(f) && c > 0 ?
                first_fail_xor : first_fail_xor),
                c > 0 ? int'(fault(m_mode, f)) : 0);
            check("vec", int'({b_out, a_out}), v);
        end
    end

    task automatic run_sweep(input int md, input int pulse_at, output int edges);
        mode = md;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pulse_at > 0 && edges == pulse_at - 1) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
            edges++;
            if (done) break;
        end
        start = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done");
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_cnt", int'(mismatch_cnt), 0);
        check("rst_vec", int'({b_out, a_out}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(0, 0, e);
        check("s1_edge", e, 512);
        check("s1_pass", int'(pass), 1);
        check("s1_cnt", int'(mismatch_cnt), 0);
        check("s1_ffv", int'(first_fail_vec), 0);
        check("s1_ffx", int'(first_fail_xor), 0);

        run_sweep(1, 0, e);
        check("s2_edge", e, STOP ? 112 : 512);
        check("s2_cnt", int'(mismatch_cnt), 1);
        check("s2_pass", int'(pass), 0);
        check("s2_ffv", int'(first_fail_vec), 8'h37);
        check("s2_ffx", int'(first_fail_xor), 1);
        check("s2_a", int'(a_out), STOP ? 4'h7 : 4'hF);
        check("s2_b", int'(b_out), STOP ? 4'h3 : 4'hF);

        run_sweep(2, 0, e);
        check("s3_edge", e, STOP ? 2 : 512);
        check("s3_cnt", int'(mismatch_cnt), STOP ? 1 : 256);
        check("s3_ffv", int'(first_fail_vec), 0);
        check("s3_ffx", int'(first_fail_xor), 4'hF);

        run_sweep(0, 100, e);
        check("s4_edge", e, 512);
        check("s4_cnt", int'(mismatch_cnt), 0);
        check("s4_pass", int'(pass), 1);

        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if ({b_out, a_out} == 8'h80) break;
            @(negedge clk);
        end
        check("s5_reach80", int'({b_out, a_out}), 8'h80);
        #2 rst_n = 1'b0;
        #1;
        check("s5_busy", int'(busy), 0);
        check("s5_done", int'(done), 0);
        check("s5_vec", int'({b_out, a_out}), 0);
        check("s5_cnt", int'(mismatch_cnt), 0);
        @(negedge clk);
        check("s5_nodone", int'(done), 0);
        #2 rst_n = 1'b1;

        run_sweep(1, 0, e);
        check("s6_edge", e, STOP ? 112 : 512);
        check("s6_cnt", int'(mismatch_cnt), 1);
        check("s6_ffv", int'(first_fail_vec), 8'h37);
        check("s6_pass", int'(pass), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
